// File: rtl/fullchip_pkg.sv
// Shared definitions for the fullchip controller: FSM encoding, instruction
// bit positions and default run geometry.
package fullchip_pkg;

    localparam int DEF_TOTAL_CYCLE = 8;
    localparam int DEF_COL         = 8;
    localparam int DEF_BW          = 8;
    localparam int DEF_PR          = 8;
    localparam int DEF_GAP         = 10;

    localparam int CNT_W  = 8;
    localparam int ADD_W  = 4;
    localparam int INST_W = 17;

    localparam int INST_OFIFO_RD = 16;
    localparam int INST_QK_ADD   = 12;
    localparam int INST_P_ADD    = 8;
    localparam int INST_EXECUTE  = 7;
    localparam int INST_LOAD     = 6;
    localparam int INST_QMEM_RD  = 5;
    localparam int INST_QMEM_WR  = 4;
    localparam int INST_KMEM_RD  = 3;
    localparam int INST_KMEM_WR  = 2;
    localparam int INST_PMEM_RD  = 1;
    localparam int INST_PMEM_WR  = 0;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_QWR   = 4'd1,
        ST_KWR   = 4'd2,
        ST_KLOAD = 4'd3,
        ST_KTAIL = 4'd4,
        ST_GAP1  = 4'd5,
        ST_EXEC  = 4'd6,
        ST_GAP2  = 4'd7,
        ST_OFIFO = 4'd8,
        ST_PRD   = 4'd9,
        ST_DONE  = 4'd10
    } state_e;

endpackage

// File: rtl/fullchip_if.sv
// Host word channel: valid/ready handshake carrying one Q or K vector per beat.
interface fullchip_if
    import fullchip_pkg::*;
#(
    parameter int DW = DEF_PR * DEF_BW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fullchip_ctrl_cnt.sv
// Shared phase counter: loadable up-counter with a terminal-count compare.
module fullchip_ctrl_cnt
    import fullchip_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] cnt_r;

    // load wins over increment so a phase change always restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (inc) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == term);
endmodule

// File: rtl/fullchip_ctrl.sv
// Run sequencer for the attention datapath: loads Q/K from the host, then steps
// through K load, execute, output FIFO drain and psum readback.
module fullchip_ctrl
    import fullchip_pkg::*;
#(
    parameter int total_cycle = DEF_TOTAL_CYCLE,
    parameter int col         = DEF_COL,
    parameter int bw          = DEF_BW,
    parameter int pr          = DEF_PR,
    parameter int gap         = DEF_GAP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    fullchip_if.slave           host,
    output logic [pr*bw-1:0]    mem_in,
    output logic [INST_W-1:0]   inst,
    output logic                busy,
    output logic                out_valid,
    output logic                done
);
    localparam logic [CNT_W-1:0] TC_Q     = CNT_W'(total_cycle - 1);
    localparam logic [CNT_W-1:0] TC_K     = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] TC_KLOAD = CNT_W'(col + 1);
    localparam logic [CNT_W-1:0] TC_GAP   = CNT_W'(gap - 1);
    localparam logic [CNT_W-1:0] TC_RUN   = CNT_W'(total_cycle);

    state_e             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_s, term_s;
    logic [ADD_W-1:0]   cnt_m1_s;
    logic               tc_s, cnt_load_s, cnt_inc_s, accept_s, abort_s;
    logic [INST_W-1:0]  inst_dec_s, inst_r;
    logic [pr*bw-1:0]   mem_in_r;
    logic               busy_r, in_ready_r, out_valid_r, done_r, prd_rd_r;

    assign abort_s  = abort && (state_r != ST_IDLE);
    assign accept_s = host.in_valid && in_ready_r && !abort_s;
    assign cnt_m1_s = cnt_s[ADD_W-1:0] - 4'd1;

    fullchip_ctrl_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_s),
        .load_val ({CNT_W{1'b0}}),
        .inc      (cnt_inc_s),
        .term     (term_s),
        .cnt      (cnt_s),
        .tc       (tc_s)
    );

    // last count value of each phase
    always_comb begin
        term_s = {CNT_W{1'b0}};
        case (state_r)
            ST_QWR:             term_s = TC_Q;
            ST_KWR:             term_s = TC_K;
            ST_KLOAD:           term_s = TC_KLOAD;
            ST_GAP1, ST_GAP2:   term_s = TC_GAP;
            ST_EXEC, ST_PRD:    term_s = TC_RUN;
            ST_OFIFO:           term_s = TC_Q;
            default:            term_s = {CNT_W{1'b0}};
        endcase
    end

    // next state and counter control; every transition reloads the counter
    always_comb begin
        state_nxt_s = state_r;
        cnt_load_s  = 1'b0;
        cnt_inc_s   = 1'b0;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
            cnt_load_s  = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_QWR;
                        cnt_load_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_QWR, ST_KWR: begin
                    if (accept_s && tc_s) begin
                        state_nxt_s = (state_r == ST_QWR) ? ST_KWR : ST_KLOAD;
                        cnt_load_s  = 1'b1;
                    end else begin
                        cnt_inc_s = accept_s;
                    end
                end
                ST_KLOAD, ST_GAP1, ST_EXEC, ST_GAP2, ST_OFIFO, ST_PRD: begin
                    if (tc_s) begin
                        case (state_r)
                            ST_KLOAD: state_nxt_s = ST_KTAIL;
                            ST_GAP1:  state_nxt_s = ST_EXEC;
                            ST_EXEC:  state_nxt_s = ST_GAP2;
                            ST_GAP2:  state_nxt_s = ST_OFIFO;
                            ST_OFIFO: state_nxt_s = ST_PRD;
                            default:  state_nxt_s = ST_DONE;
                        endcase
                        cnt_load_s = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
                ST_KTAIL: begin
                    state_nxt_s = ST_GAP1;
                    cnt_load_s  = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_load_s  = 1'b1;
                end
            endcase
        end
    end

    // instruction for the current state/count, registered below
    always_comb begin
        inst_dec_s = {INST_W{1'b0}};
        case (state_r)
            ST_QWR, ST_KWR: begin
                if (accept_s) begin
                    inst_dec_s[(state_r == ST_QWR) ? INST_QMEM_WR : INST_KMEM_WR] = 1'b1;
                    inst_dec_s[INST_QK_ADD +: ADD_W] = cnt_s[ADD_W-1:0];
                end else begin
                    inst_dec_s = {INST_W{1'b0}};
                end
            end
            ST_KLOAD: begin
                inst_dec_s[INST_LOAD]    = 1'b1;
                inst_dec_s[INST_KMEM_RD] = (cnt_s >= CNT_W'(1));
                if (cnt_s < CNT_W'(2)) begin
                    inst_dec_s[INST_QK_ADD +: ADD_W] = 4'd0;
                end else begin
                    inst_dec_s[INST_QK_ADD +: ADD_W] = cnt_m1_s;
                end
            end
            ST_KTAIL: inst_dec_s[INST_LOAD] = 1'b1;
            ST_EXEC: begin
                inst_dec_s[INST_EXECUTE] = 1'b1;
                inst_dec_s[INST_QMEM_RD] = 1'b1;
                inst_dec_s[INST_QK_ADD +: ADD_W] = cnt_s[ADD_W-1:0];
            end
            ST_OFIFO: begin
                inst_dec_s[INST_OFIFO_RD] = 1'b1;
                inst_dec_s[INST_PMEM_WR]  = 1'b1;
                inst_dec_s[INST_P_ADD +: ADD_W] = cnt_s[ADD_W-1:0];
            end
            ST_PRD: begin
                inst_dec_s[INST_PMEM_RD] = 1'b1;
                inst_dec_s[INST_P_ADD +: ADD_W] = cnt_s[ADD_W-1:0];
            end
            default: inst_dec_s = {INST_W{1'b0}};
        endcase
    end

    // state register and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            inst_r      <= {INST_W{1'b0}};
            mem_in_r    <= {(pr*bw){1'b0}};
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            prd_rd_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            in_ready_r <= (state_nxt_s == ST_QWR) || (state_nxt_s == ST_KWR);
            done_r     <= (state_nxt_s == ST_DONE);
            if (abort_s) begin
                inst_r      <= {INST_W{1'b0}};
                prd_rd_r    <= 1'b0;
                out_valid_r <= 1'b0;
            end else begin
                inst_r      <= inst_dec_s;
                // psum SRAM returns data one cycle after the read instruction
                prd_rd_r    <= (state_r == ST_PRD) && (cnt_s < TC_RUN);
                out_valid_r <= prd_rd_r;
            end
            if (accept_s) begin
                mem_in_r <= host.in_data;
            end else begin
                mem_in_r <= mem_in_r;
            end
        end
    end

    assign host.in_ready = in_ready_r;
    assign mem_in        = mem_in_r;
    assign inst          = inst_r;
    assign busy          = busy_r;
    assign out_valid     = out_valid_r;
    assign done          = done_r;
endmodule

// File: tb/tb_fullchip_ctrl.sv
// Scoreboard bench for fullchip_ctrl: expected output events are queued per run
// and a negedge monitor compares each non-idle output cycle, including idle gaps.
module tb_fullchip_ctrl;
    localparam int DW = 64;
    localparam logic [16:0] I_OFIFO = 17'h10000;
    localparam logic [16:0] I_EXEC  = 17'h00080;
    localparam logic [16:0] I_LOAD  = 17'h00040;
    localparam logic [16:0] I_QRD   = 17'h00020;
    localparam logic [16:0] I_QWR   = 17'h00010;
    localparam logic [16:0] I_KRD   = 17'h00008;
    localparam logic [16:0] I_KWR   = 17'h00004;
    localparam logic [16:0] I_PRD   = 17'h00002;
    localparam logic [16:0] I_PWR   = 17'h00001;

    typedef struct {
        logic [82:0] ev;
        int          quiet;
    } exp_t;

    logic clk = 1'b0;
    logic reset, start0, start1, abort0, abort1;
    logic [DW-1:0] mem_in0, mem_in1;
    logic [16:0]   inst0, inst1;
    logic busy0, busy1, ov0, ov1, done0, done1;
    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   quiet_c [2] = '{0, 0};
    int   done_cnt [2] = '{0, 0};
    int   acc0 = 0;
    int   acc1 = 0;
    int   base;

    always #5 clk = ~clk;

    fullchip_if #(.DW(DW)) h0 ();
    fullchip_if #(.DW(DW)) h1 ();

    fullchip_ctrl #(.total_cycle(8), .col(8), .bw(8), .pr(8), .gap(10)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0), .host(h0),
        .mem_in(mem_in0), .inst(inst0), .busy(busy0), .out_valid(ov0), .done(done0)
    );

    fullchip_ctrl #(.total_cycle(4), .col(4), .bw(8), .pr(8), .gap(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .host(h1),
        .mem_in(mem_in1), .inst(inst1), .busy(busy1), .out_valid(ov1), .done(done1)
    );

    function automatic logic [63:0] word(input int i);
        logic [7:0] b;
        b = 8'(i * 37 + 5);
        return {8{b}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [16:0] qk_add(input int a);
        return {1'b0, 4'(a), 12'h000};
    endfunction

    function automatic logic [16:0] p_add(input int a);
        return {5'b00000, 4'(a), 8'h00};
    endfunction

    // host word index: restarts with each run, advances on every handshake
    always @(posedge clk) begin
        if (start0 && !busy0) acc0 <= 0;
        else if (h0.in_valid && h0.in_ready) acc0 <= acc0 + 1;
        if (start1 && !busy1) acc1 <= 0;
        else if (h1.in_valid && h1.in_ready) acc1 <= acc1 + 1;
    end

    assign h0.in_data = word(acc0);
    assign h1.in_data = word(acc1);

    task automatic chk(input string nm, input logic [82:0] act, input logic [82:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input logic dn, input logic ov, input logic [16:0] ins,
                        input logic [63:0] m, input int qt);
        exp_t e;
        e.ev = {dn, ov, ins, m};
        e.quiet = qt;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // stop_kind 1: run ends after EXEC count stop_at; 2: after KLOAD count stop_at
    task automatic gen_run(input int d, input int t, input int c, input int g, input int qgap,
                           input int stop_kind, input int stop_at);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < t; i++) begin
            m = word(i);
            push(d, 1'b0, 1'b0, I_QWR | qk_add(i), m, (i == 0) ? 1 : qgap);
        end
        for (int i = 0; i < c; i++) begin
            m = word(t + i);
            push(d, 1'b0, 1'b0, I_KWR | qk_add(i), m, 0);
        end
        for (int k = 0; k < c + 2; k++) begin
            push(d, 1'b0, 1'b0, I_LOAD | ((k >= 1) ? I_KRD : 17'h0) | qk_add((k < 2) ? 0 : k - 1), m, 0);
            if (stop_kind == 2 && k == stop_at) return;
        end
        push(d, 1'b0, 1'b0, I_LOAD, m, 0);
        for (int k = 0; k <= t; k++) begin
            push(d, 1'b0, 1'b0, I_EXEC | I_QRD | qk_add(k), m, (k == 0) ? g : 0);
            if (stop_kind == 1 && k == stop_at) return;
        end
        for (int k = 0; k < t; k++)
            push(d, 1'b0, 1'b0, I_OFIFO | I_PWR | p_add(k), m, (k == 0) ? g : 0);
        for (int k = 0; k <= t; k++)
            push(d, (k == t), (k >= 1), I_PRD | p_add(k), m, 0);
    endtask

    task automatic mon_step(input int d, input logic st, input logic bsy, input logic dn,
                            input logic ov, input logic [16:0] ins, input logic [63:0] m);
        exp_t e;
        logic [82:0] obs;
        obs = {dn, ov, ins, m};
        if (dn) done_cnt[d]++;
        if ({dn, ov, ins} != 19'd0) begin
            n_checks++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_fail++;
                $display("FAIL unexpected_event dut%0d: got %h, expected no output", d, obs);
            end else begin
                if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                if (obs !== e.ev || quiet_c[d] != e.quiet) begin
                    n_fail++;
                    $display("FAIL event dut%0d: got %h after %0d idle, expected %h after %0d idle",
                             d, obs, quiet_c[d], e.ev, e.quiet);
                end
            end
            quiet_c[d] = 0;
        end else if (st && !bsy) begin
            quiet_c[d] = 0;
        end else begin
            quiet_c[d]++;
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon_step(0, start0, busy0, done0, ov0, inst0, mem_in0);
        mon_step(1, start1, busy1, done1, ov1, inst1, mem_in1);
    end

    task automatic start_run(input int d);
        @(posedge clk); #1;
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        if (d == 0) start0 = 1'b0; else start1 = 1'b0;
    endtask

    task automatic wait_inst(input logic [16:0] pat, input int maxc);
        int n = 0;
        logic hit = 1'b0;
        while (!hit && n < maxc) begin
            @(negedge clk);
            n++;
            hit = (inst0 == pat);
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_inst: got no inst %h within %0d cycles, expected it", pat, maxc);
        end
    endtask

    task automatic wait_idle(input int d, input int maxc);
        int n = 0;
        logic bsy = 1'b1;
        while (bsy && n < maxc) begin
            @(negedge clk);
            n++;
            bsy = (d == 0) ? busy0 : busy1;
        end
        n_checks++;
        if (bsy) begin
            n_fail++;
            $display("FAIL wait_idle dut%0d: got busy after %0d cycles, expected idle", d, maxc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected one");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
        h0.in_valid = 1'b0; h1.in_valid = 1'b0;
        #12;
        chk("reset_out0", 83'({busy0, h0.in_ready, ov0, done0, inst0, mem_in0}), 83'(0));
        chk("reset_out1", 83'({busy1, h1.in_ready, ov1, done1, inst1, mem_in1}), 83'(0));
        @(negedge clk); reset = 1'b1;
        h0.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_without_start", 83'({busy0, h0.in_ready}), 83'(0));

        // full run, with a start pulse ignored during OFIFO
        base = done_cnt[0];
        gen_run(0, 8, 8, 10, 0, 0, 0);
        start_run(0);
        wait_inst(I_OFIFO | I_PWR, 200);
        #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        wait_idle(0, 200);
        repeat (3) @(negedge clk);
        chk("runA_done_count", 83'(done_cnt[0] - base), 83'(1));
        chk("runA_queue_empty", 83'(q0.size()), 83'(0));
        chk("runA_no_restart", 83'(busy0), 83'(0));

        // in_valid toggling during QWR
        base = done_cnt[0];
        gen_run(0, 8, 8, 10, 1, 0, 0);
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int k = 1; k < 15; k++) begin
            @(posedge clk); #1;
            h0.in_valid = (k % 2 == 0);
        end
        @(posedge clk); #1 h0.in_valid = 1'b1;
        wait_idle(0, 200);
        @(negedge clk);
        chk("runB_done_count", 83'(done_cnt[0] - base), 83'(1));
        chk("runB_queue_empty", 83'(q0.size()), 83'(0));

        // abort at EXEC cnt=4 (the cycle showing EXEC address 3)
        base = done_cnt[0];
        gen_run(0, 8, 8, 10, 0, 1, 3);
        start_run(0);
        wait_inst(I_EXEC | I_QRD | qk_add(3), 200);
        abort0 = 1'b1;
        @(posedge clk); #1;
        chk("abort_inst", 83'(inst0), 83'(0));
        chk("abort_busy_ready", 83'({busy0, h0.in_ready}), 83'(0));
        abort0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 83'(done_cnt[0] - base), 83'(0));
        chk("abort_queue_empty", 83'(q0.size()), 83'(0));

        // fresh run after abort
        base = done_cnt[0];
        gen_run(0, 8, 8, 10, 0, 0, 0);
        start_run(0);
        wait_idle(0, 200);
        @(negedge clk);
        chk("runD_done_count", 83'(done_cnt[0] - base), 83'(1));
        chk("runD_queue_empty", 83'(q0.size()), 83'(0));

        // reset at KLOAD cnt=3 (the cycle showing KLOAD count 2)
        base = done_cnt[0];
        gen_run(0, 8, 8, 10, 0, 2, 2);
        start_run(0);
        wait_inst(I_LOAD | I_KRD | qk_add(1), 200);
        #1 reset = 1'b0;
        #1;
        chk("midrun_reset_out", 83'({busy0, h0.in_ready, ov0, done0, inst0, mem_in0}), 83'(0));
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("after_reset_idle", 83'({busy0, h0.in_ready}), 83'(0));
        chk("after_reset_no_done", 83'(done_cnt[0] - base), 83'(0));
        chk("after_reset_queue_empty", 83'(q0.size()), 83'(0));

        // scaled parameters: total_cycle=4, col=4, gap=2
        gen_run(1, 4, 4, 2, 0, 0, 0);
        h1.in_valid = 1'b1;
        start_run(1);
        wait_idle(1, 200);
        @(negedge clk);
        chk("small_done_count", 83'(done_cnt[1]), 83'(1));
        chk("small_queue_empty", 83'(q1.size()), 83'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fullchip_ctrl.md
FULLCHIP_CTRL -- requirements
Module: fullchip_ctrl

Interface
REQ-001 Parameter total_cycle, default 8: number of Q vectors per run.
REQ-002 Parameter col, default 8: number of K vectors (dot-product units).
REQ-003 Parameter bw, default 8; parameter pr, default 8: element width and elements per vector.
REQ-004 Parameter gap, default 10: idle cycles inserted after K load and after execute.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle run request; sampled only in IDLE.
REQ-008 abort  in  1  synchronous abort of a run in progress.
REQ-009 in_valid  in  1  host word valid; in_ready  out  1  controller accepts the word.
REQ-010 in_data  in  pr*bw  host Q or K vector.
REQ-011 mem_in  out  pr*bw  registered copy of the accepted in_data, driven to the datapath.
REQ-012 inst  out  17  registered datapath instruction:
- [16] ofifo_rd; [15:12] qkmem_add; [11:8] pmem_add
- [7] execute; [6] load; [5] qmem_rd; [4] qmem_wr
- [3] kmem_rd; [2] kmem_wr; [1] pmem_rd; [0] pmem_wr
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 out_valid  out  1  datapath output is valid this cycle.
REQ-015 done  out  1  one-cycle pulse at the end of a run.

Function
REQ-016 The FSM SHALL use these states: IDLE, QWR, KWR, KLOAD, KTAIL, GAP1, EXEC, GAP2, OFIFO, PRD, DONE; cnt is one shared counter, cleared on every state entry.
REQ-017 IDLE: start=1 SHALL move the FSM to QWR; start in any other state SHALL be ignored.
REQ-018 in_ready SHALL be high only in QWR and KWR; a word is accepted on in_valid&in_ready.
REQ-019 QWR: each accepted word SHALL produce, one cycle later, qmem_wr=1, qkmem_add=cnt, mem_in=in_data, then cnt+1.
- A cycle with no acceptance SHALL drive qmem_wr=0.
- After total_cycle accepted words the FSM SHALL go to KWR.
REQ-020 KWR: same rule as REQ-019 using kmem_wr; after col accepted words the FSM SHALL go to KLOAD.
REQ-021 KLOAD SHALL last col+2 cycles with load=1; kmem_rd=1 when cnt>=1; qkmem_add=0 when cnt<2, otherwise cnt-1.
REQ-022 KTAIL SHALL last one cycle with load=1, kmem_rd=0, qkmem_add=0.
REQ-023 GAP1 and GAP2 SHALL each last gap cycles with inst=0.
REQ-024 EXEC SHALL last total_cycle+1 cycles with execute=1, qmem_rd=1, qkmem_add=cnt; it is followed by GAP2.
REQ-025 OFIFO SHALL last total_cycle cycles with ofifo_rd=1, pmem_wr=1, pmem_add=cnt.
REQ-026 PRD SHALL last total_cycle+1 cycles with pmem_rd=1, pmem_add=cnt.
- out_valid SHALL be high exactly one cycle after each PRD cycle with cnt<total_cycle (SRAM read latency 1), i.e. total_cycle pulses.
REQ-027 DONE SHALL last one cycle: done=1, inst=0; the FSM then returns to IDLE.
REQ-028 Address fields SHALL be 4-bit and truncate on overflow; no error is flagged.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with inst=0, in_ready=0, no done pulse and counters cleared.
- abort has priority over in_valid acceptance in the same cycle.
REQ-030 All inst bits not named for a state SHALL be 0.

Reset
REQ-031 reset=0 SHALL immediately and asynchronously force state=IDLE, cnt=0, inst=0, mem_in=0, busy=0, in_ready=0, out_valid=0, done=0, including in the middle of a run.
REQ-032 After reset deasserts, no action SHALL occur until start is sampled.

Structure
REQ-033 A shared package fullchip_pkg SHALL hold the FSM state encoding, the inst bit-position constants and the default parameter values.
REQ-034 A sub-module fullchip_ctrl_cnt (loadable up-counter with terminal-count flag) SHALL provide cnt; everything else is one FSM in fullchip_ctrl.

Verification
REQ-035 Full run with defaults and in_valid held high: 8 qmem_wr cycles (addresses 0..7), then 8 kmem_wr cycles (addresses 0..7), then a 10-cycle KLOAD with kmem_rd starting in cycle 2, KTAIL, 10 idle cycles, a 9-cycle EXEC with qkmem_add 0..8, 10 idle cycles, OFIFO with pmem_add 0..7, a 9-cycle PRD, 8 out_valid pulses, done=1 once.
REQ-036 in_valid toggling 1,0,1,0 during QWR: qmem_wr only follows accepted cycles and qkmem_add increments only on acceptance.
REQ-037 abort asserted at EXEC cnt=4: inst=0 and busy=0 on the next cycle, no done; a new start then produces a correct full run.
REQ-038 reset pulsed low at KLOAD cnt=3: all outputs read 0 before the next clock edge, and the FSM is in IDLE.
REQ-039 start asserted while busy in OFIFO: no effect, and exactly one done pulse.
REQ-040 Parameters total_cycle=4, col=4, gap=2: the durations of all phases scale per REQ-021 to REQ-026.
